// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand fetch / issue stage with busy scoreboard (optional macro: ISSUE_BYPASS_EN)
module alu_issue_stage #(
  parameter int WIDTH = 19,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [WIDTH-1:0] instr_data,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_opcode,
  output logic [2:0]       iss_rd,
  input  logic             wb_en,
  input  logic [2:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic [NREGS-1:0] busy_mask,
  output logic             illegal_op
);

  logic [WIDTH-1:0] r_rf [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             r_iss_valid;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [4:0]       r_alu_opcode;
  logic [2:0]       r_iss_rd;
  logic             r_illegal;

  logic [4:0]       w_op;
  logic [2:0]       w_rd;
  logic [2:0]       w_rs1;
  logic [2:0]       w_rs2;
  logic [4:0]       w_unused_rsvd;
  logic             w_legal;
  logic             w_unary;
  logic             w_binary;
  logic             w_illegal;
  logic [NREGS-1:0] w_wb_mask;
  logic [NREGS-1:0] w_busy_eff;
  logic             w_wb_hit;
  logic             w_hazard;
  logic             w_accept;
  logic [WIDTH-1:0] w_rs1_val;
  logic [WIDTH-1:0] w_rs2_val;

  assign w_op          = instr_data[18:14];
  assign w_rd          = instr_data[13:11];
  assign w_rs1         = instr_data[10:8];
  assign w_rs2         = instr_data[7:5];
  assign w_unused_rsvd = instr_data[4:0];

  assign w_legal   = (w_op >= 5'd1) && (w_op <= 5'd10);
  assign w_unary   = (w_op == 5'd5) || (w_op == 5'd6) || (w_op == 5'd10);
  assign w_binary  = w_legal && !w_unary;
  assign w_illegal = (w_op >= 5'd11);

  assign w_wb_mask = wb_en ? (NREGS'(1) << wb_rd) : '0;

`ifdef ISSUE_BYPASS_EN
  // A register being written back this cycle is treated as ready and its new value is forwarded.
  assign w_busy_eff = r_busy & ~w_wb_mask;
  assign w_wb_hit   = 1'b0;
  assign w_rs1_val  = (wb_en && (wb_rd == w_rs1)) ? wb_data : r_rf[w_rs1];
  assign w_rs2_val  = (wb_en && (wb_rd == w_rs2)) ? wb_data : r_rf[w_rs2];
`else
  // Without forwarding, any write-back touching a used register stalls one cycle so the read sees the new value.
  assign w_busy_eff = r_busy;
  assign w_wb_hit   = wb_en && ((wb_rd == w_rs1) || (w_binary && (wb_rd == w_rs2)) || (wb_rd == w_rd));
  assign w_rs1_val  = r_rf[w_rs1];
  assign w_rs2_val  = r_rf[w_rs2];
`endif

  assign w_hazard = w_legal && (w_busy_eff[w_rs1] || (w_binary && w_busy_eff[w_rs2]) ||
                                w_busy_eff[w_rd] || w_wb_hit);

  assign instr_ready = (!r_iss_valid || iss_ready) && !w_hazard;
  assign w_accept    = instr_valid && instr_ready;

  // Issue register: load on a legal accept, hold while stalled, drop valid after a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_valid  <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= '0;
      r_iss_rd     <= '0;
    end else if (w_accept && w_legal) begin
      r_iss_valid  <= 1'b1;
      r_alu_a      <= w_rs1_val;
      r_alu_b      <= w_unary ? '0 : w_rs2_val;
      r_alu_opcode <= w_op;
      r_iss_rd     <= w_rd;
    end else if (r_iss_valid && iss_ready) begin
      r_iss_valid  <= 1'b0;
    end
  end

  // Illegal opcodes are swallowed and flagged for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && w_illegal;
    end
  end

  // Scoreboard: write-back clears, a new destination sets, and the set wins on collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_wb_mask) | ((w_accept && w_legal) ? (NREGS'(1) << w_rd) : '0);
    end
  end

  // Register file write port, fed only by the write-back bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (wb_en) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  assign iss_valid  = r_iss_valid;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_opcode;
  assign iss_rd     = r_iss_rd;
  assign busy_mask  = r_busy;
  assign illegal_op = r_illegal;

endmodule
